// File: rtl/req_age_queue.sv
// req_age_queue: in-order request buffer that ages every resident entry each
// cycle and releases the head only after it has been resident AGE_LIMIT cycles.
// Requests with a negative or non-increasing timestamp are handshaked and
// discarded.
// Optional build macro REQ_QUEUE_STATS_EN enables the high-water mark, the
// drop counter and the simulation-only drop trace.
module req_age_queue #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 33,
   parameter int OP_W      = 2,
   parameter int TIME_W    = 32,
   parameter int AGE_W     = 8,
   parameter int AGE_LIMIT = 100
) (
   input  logic                     CPU_clock,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [TIME_W-1:0]        in_time,
   input  logic [OP_W-1:0]          in_opcode,
   input  logic [ADDR_W-1:0]        in_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TIME_W-1:0]        out_time,
   output logic [OP_W-1:0]          out_opcode,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [AGE_W-1:0]         out_age,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     insert_flag,
   output logic                     exit_flag,
   output logic                     drop_flag,
   output logic [$clog2(DEPTH):0]   max_count,
   output logic [15:0]              drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   logic [TIME_W-1:0] time_mem [DEPTH];
   logic [OP_W-1:0]   op_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [AGE_W-1:0]  age_mem  [DEPTH];
   logic [DEPTH-1:0]  occ;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [TIME_W-1:0] last_time_q;
   logic              first_q;

   logic push_hs;
   logic stale;
   logic is_drop;
   logic do_wr;
   logic do_pop;

   assign count    = count_q;
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;

   assign out_age    = empty ? '0 : age_mem[rd_ptr];
   assign out_time   = empty ? '0 : time_mem[rd_ptr];
   assign out_opcode = empty ? '0 : op_mem[rd_ptr];
   assign out_addr   = empty ? '0 : addr_mem[rd_ptr];
   assign out_valid  = !empty && (age_mem[rd_ptr] >= AGE_LIM);

   // Non-negative timestamps only reach the compare, so unsigned ordering is safe.
   assign push_hs = in_valid && in_ready;
   assign stale   = !first_q && (in_time <= last_time_q);
   assign is_drop = push_hs && (in_time[TIME_W-1] || stale);
   assign do_wr   = push_hs && !is_drop;
   assign do_pop  = out_valid && out_ready;

   // Payload storage; contents are only observed while the slot is occupied.
   always_ff @(posedge CPU_clock) begin
      if (do_wr) begin
         time_mem[wr_ptr] <= in_time;
         op_mem[wr_ptr]   <= in_opcode;
         addr_mem[wr_ptr] <= in_addr;
      end
   end

   // Per-slot occupancy and saturating age counters.
   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         occ <= '0;
         for (int i = 0; i < DEPTH; i++) age_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_wr && (wr_ptr == PTR_W'(i))) begin
               occ[i]     <= 1'b1;
               age_mem[i] <= '0;
            end else if (do_pop && (rd_ptr == PTR_W'(i))) begin
               occ[i]     <= 1'b0;
               age_mem[i] <= '0;
            end else if (occ[i] && (age_mem[i] != AGE_MAX)) begin
               age_mem[i] <= age_mem[i] + 1'b1;
            end
         end
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks push/pop.
   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Ordering reference: last accepted timestamp, "first" allows any value.
   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         last_time_q <= '0;
         first_q     <= 1'b1;
      end else if (do_wr) begin
         last_time_q <= in_time;
         first_q     <= 1'b0;
      end
   end

   // Single-cycle event pulses.
   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         insert_flag <= 1'b0;
         exit_flag   <= 1'b0;
         drop_flag   <= 1'b0;
      end else begin
         insert_flag <= do_wr;
         exit_flag   <= do_pop;
         drop_flag   <= is_drop;
      end
   end

`ifdef REQ_QUEUE_STATS_EN
   logic [CNT_W-1:0] max_q;
   logic [15:0]      drop_q;

   assign max_count  = max_q;
   assign drop_count = drop_q;

   // High-water mark and saturating drop counter.
   always_ff @(posedge CPU_clock or posedge rst) begin
      if (rst) begin
         max_q  <= '0;
         drop_q <= '0;
      end else begin
         if (count_q > max_q) max_q <= count_q;
         if (is_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
      end
   end

`ifndef SYNTHESIS
   // Simulation-only trace of discarded requests.
   always @(posedge CPU_clock) begin
      if (!rst && is_drop)
         $display("%t : DROPPED : time=%0d opcode=%0d addr=0x%h",
                  $time, in_time, in_opcode, in_addr);
   end
`endif
`else
   assign max_count  = '0;
   assign drop_count = '0;
`endif

endmodule
